// File: rtl/frost_scene_core.sv
// Per-pixel scene core: background/sprite ROM addressing, animation frame select,
// color-key compositing and sticky ground-block touch detection.
module frost_scene_core #(
  parameter int unsigned ANIM_PERIOD = 6_000_000,
  parameter int unsigned BG_W        = 551,
  parameter int unsigned BG_H        = 401,
  parameter int unsigned SPR_W       = 47,
  parameter int unsigned SPR_H       = 41,
  parameter int unsigned BLK_W       = 28,
  parameter logic [11:0] KEY0        = 12'h428,
  parameter logic [11:0] KEY1        = 12'h028
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  col_addr_x,
  input  logic [8:0]  row_addr_y,
  input  logic [9:0]  x_blue,
  input  logic [8:0]  y_blue,
  input  logic [2:0]  blue_state,
  input  logic [9:0]  x_ground,
  input  logic [8:0]  y_ground,
  output logic [18:0] bg_addr,
  output logic [13:0] blue_addr,
  output logic [2:0]  blue_sel,
  input  logic [11:0] bg_pix,
  input  logic [11:0] blue_pix,
  output logic [11:0] pixel_out,
  output logic        touched
);

  localparam int unsigned CW     = 11;
  localparam int unsigned BG_AW  = 19;
  localparam int unsigned SPR_AW = 14;
  localparam int unsigned CNT_W  = 32;

  // Widen everything to 11 bits so x+46 / y+40 never wrap.
  logic [CW-1:0] x, y, bx, by, gx, gy, dx, dy;
  assign x  = CW'(col_addr_x);
  assign y  = CW'(row_addr_y);
  assign bx = CW'(x_blue);
  assign by = CW'(y_blue);
  assign gx = CW'(x_ground);
  assign gy = CW'(y_ground);
  assign dx = x - bx;
  assign dy = y - by;

  logic              bg_in, hit_d, touch_d, wrap, opaque;
  logic [BG_AW-1:0]  bg_addr_d;
  logic [SPR_AW-1:0] blue_addr_d;

  always_comb begin
    bg_in       = (x <= CW'(BG_W - 1)) && (y <= CW'(BG_H - 1));
    hit_d       = (x >= bx) && (x <= bx + CW'(SPR_W - 1)) &&
                  (y >= by) && (y <= by + CW'(SPR_H - 1));
    bg_addr_d   = '0;
    blue_addr_d = '0;
    if (bg_in)
      bg_addr_d = BG_AW'(y) * BG_AW'(BG_W) + BG_AW'(x);
    if (hit_d)
      blue_addr_d = SPR_AW'(dy) * SPR_AW'(SPR_W) + SPR_AW'(dx);
  end

  // Feet row sits directly on the block top and the x spans overlap.
  assign touch_d = (by + CW'(SPR_H) == gy) &&
                   (bx <= gx + CW'(BLK_W - 1)) &&
                   (gx <= bx + CW'(SPR_W - 1));

  logic [CNT_W-1:0] ipcnt;
  logic [1:0]       frame;
  logic             hit_q1, hit_q2;

  assign wrap   = (ipcnt == CNT_W'(ANIM_PERIOD));
  assign opaque = hit_q2 && (blue_pix != KEY0) && (blue_pix != KEY1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ipcnt     <= '0;
      frame     <= '0;
      bg_addr   <= '0;
      blue_addr <= '0;
      blue_sel  <= '0;
      hit_q1    <= 1'b0;
      hit_q2    <= 1'b0;
      pixel_out <= '0;
      touched   <= 1'b0;
    end else begin
      ipcnt <= wrap ? '0 : ipcnt + CNT_W'(1);
      // Frame only advances or clears at a wrap, so blue_state[2] takes effect there.
      if (wrap)
        frame <= blue_state[2] ? frame + 2'd1 : 2'd0;
      bg_addr   <= bg_addr_d;
      blue_addr <= blue_addr_d;
      blue_sel  <= {blue_state[0], frame};
      hit_q1    <= hit_d;
      hit_q2    <= hit_q1;
      pixel_out <= opaque ? blue_pix : bg_pix;
      if (touch_d)
        touched <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frost_scene_core.sv
// Directed bench for frost_scene_core: address/compositing vector table,
// animation frame stepping, touch detection and mid-stream reset.
module tb_frost_scene_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  col_addr_x, x_blue, x_ground;
  logic [8:0]  row_addr_y, y_blue, y_ground;
  logic [2:0]  blue_state;
  logic [18:0] bg_addr;
  logic [13:0] blue_addr;
  logic [2:0]  blue_sel;
  logic [11:0] bg_pix, blue_pix, pixel_out, spr_data;
  logic        touched;

  int n_chk = 0;
  int n_bad = 0;

  frost_scene_core #(.ANIM_PERIOD(3)) dut (
    .clk(clk), .rst(rst),
    .col_addr_x(col_addr_x), .row_addr_y(row_addr_y),
    .x_blue(x_blue), .y_blue(y_blue), .blue_state(blue_state),
    .x_ground(x_ground), .y_ground(y_ground),
    .bg_addr(bg_addr), .blue_addr(blue_addr), .blue_sel(blue_sel),
    .bg_pix(bg_pix), .blue_pix(blue_pix),
    .pixel_out(pixel_out), .touched(touched)
  );

  always #5 clk = ~clk;

  // ROM stand-ins with one-cycle read latency.
  always @(posedge clk) begin
    bg_pix   <= 12'(bg_addr) ^ 12'hA5A;
    blue_pix <= spr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] spr;
    logic [18:0] bg;
    logic [13:0] ba;
    logic        opq;
  } vec_t;

  typedef struct packed {
    logic [9:0] xb;
    logic [8:0] yb;
    logic       exp;
  } tvec_t;

  vec_t  vecs[13];
  tvec_t tvecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] exp_pix;
    vecs[0]  = '{10'd10,  9'd2,   12'hFFF, 19'd1112,   14'd0,    1'b0};
    vecs[1]  = '{10'd551, 9'd2,   12'hFFF, 19'd0,      14'd0,    1'b0};
    vecs[2]  = '{10'd550, 9'd400, 12'hFFF, 19'd220950, 14'd0,    1'b0};
    vecs[3]  = '{10'd10,  9'd401, 12'hFFF, 19'd0,      14'd0,    1'b0};
    vecs[4]  = '{10'd146, 9'd90,  12'hFFF, 19'd49736,  14'd1926, 1'b1};
    vecs[5]  = '{10'd147, 9'd90,  12'hFFF, 19'd49737,  14'd0,    1'b0};
    vecs[6]  = '{10'd100, 9'd50,  12'h428, 19'd27650,  14'd0,    1'b0};
    vecs[7]  = '{10'd101, 9'd51,  12'h028, 19'd28202,  14'd48,   1'b0};
    vecs[8]  = '{10'd120, 9'd60,  12'h123, 19'd33180,  14'd490,  1'b1};
    vecs[9]  = '{10'd100, 9'd91,  12'h123, 19'd50241,  14'd0,    1'b0};
    vecs[10] = '{10'd99,  9'd50,  12'h123, 19'd27649,  14'd0,    1'b0};
    vecs[11] = '{10'd146, 9'd49,  12'h123, 19'd27145,  14'd0,    1'b0};
    vecs[12] = '{10'd146, 9'd50,  12'h427, 19'd27696,  14'd46,   1'b1};

    tvecs[0] = '{10'd20, 9'd333, 1'b1};
    tvecs[1] = '{10'd85, 9'd333, 1'b0};
    tvecs[2] = '{10'd83, 9'd333, 1'b1};
    tvecs[3] = '{10'd84, 9'd333, 1'b0};
    tvecs[4] = '{10'd9,  9'd333, 1'b0};
    tvecs[5] = '{10'd10, 9'd333, 1'b1};
    tvecs[6] = '{10'd20, 9'd332, 1'b0};
    tvecs[7] = '{10'd20, 9'd334, 1'b0};

    rst = 1'b1;
    col_addr_x = '0; row_addr_y = '0;
    x_blue = 10'd100; y_blue = 9'd50; blue_state = 3'b000;
    x_ground = '0; y_ground = '0; spr_data = 12'hFFF;
    edges(2);
    check("rst_bg_addr", 32'(bg_addr), 0);
    check("rst_blue_addr", 32'(blue_addr), 0);
    check("rst_blue_sel", 32'(blue_sel), 0);
    check("rst_pixel", 32'(pixel_out), 0);
    check("rst_touched", 32'(touched), 0);
    rst = 1'b0;

    // Address and compositing vectors, inputs held through the whole pipeline.
    for (int i = 0; i < 13; i++) begin
      col_addr_x = vecs[i].x;
      row_addr_y = vecs[i].y;
      spr_data   = vecs[i].spr;
      edges(1);
      check($sformatf("v%0d_bg_addr", i), 32'(bg_addr), 32'(vecs[i].bg));
      check($sformatf("v%0d_blue_addr", i), 32'(blue_addr), 32'(vecs[i].ba));
      edges(2);
      exp_pix = vecs[i].opq ? vecs[i].spr : (12'(vecs[i].bg) ^ 12'hA5A);
      check($sformatf("v%0d_pixel", i), 32'(pixel_out), 32'(exp_pix));
    end

    // Single inside pixel in a stream of outside pixels lands exactly at N+3.
    spr_data = 12'hFFF;
    col_addr_x = 10'd10; row_addr_y = 9'd2;
    edges(4);
    col_addr_x = 10'd146; row_addr_y = 9'd90;
    edges(1);
    col_addr_x = 10'd10; row_addr_y = 9'd2;
    edges(1);
    check("lat_n2", 32'(pixel_out), 32'h0E02);
    edges(1);
    check("lat_n3", 32'(pixel_out), 32'h0FFF);
    edges(1);
    check("lat_n4", 32'(pixel_out), 32'h0E02);

    // Animation: period 4 cycles, blue_sel lags frame by one register stage.
    @(negedge clk);
    rst = 1'b1;
    blue_state = 3'b101;
    edges(1);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      edges(1);
      check($sformatf("anim_e%0d", k), 32'(blue_sel), 32'(4 + ((k - 1) / 4) % 4));
    end
    blue_state = 3'b001;
    edges(2);
    check("stop_hold_e22", 32'(blue_sel), 32'd5);
    edges(3);
    check("stop_clear_e25", 32'(blue_sel), 32'd4);
    edges(4);
    check("stop_stay_e29", 32'(blue_sel), 32'd4);

    // Touch detection across overlap boundaries and feet-row alignment.
    x_ground = 10'd56; y_ground = 9'd374;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      x_blue = tvecs[i].xb;
      y_blue = tvecs[i].yb;
      check($sformatf("t%0d_pre", i), 32'(touched), 0);
      edges(2);
      check($sformatf("t%0d_touched", i), 32'(touched), 32'(tvecs[i].exp));
    end

    // Sticky after the player leaves, then mid-stream reset clears everything.
    do_reset();
    x_blue = 10'd20; y_blue = 9'd333;
    edges(1);
    check("touch_next_cycle", 32'(touched), 1);
    x_blue = 10'd300; y_blue = 9'd100;
    col_addr_x = 10'd310; row_addr_y = 9'd110;
    blue_state = 3'b111;
    edges(6);
    check("touch_sticky", 32'(touched), 1);
    rst = 1'b1;
    edges(1);
    check("mid_bg_addr", 32'(bg_addr), 0);
    check("mid_blue_addr", 32'(blue_addr), 0);
    check("mid_blue_sel", 32'(blue_sel), 0);
    check("mid_pixel", 32'(pixel_out), 0);
    check("mid_touched", 32'(touched), 0);
    rst = 1'b0;
    blue_state = 3'b101;
    edges(4);
    check("restart_e4", 32'(blue_sel), 32'd4);
    edges(1);
    check("restart_e5", 32'(blue_sel), 32'd5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/frost_scene_core.md
# frost_scene_core

Per-pixel scene core for the Jack-Frost game. For each VGA scan coordinate it generates the background and player-sprite ROM read addresses, and picks the player animation frame from a free-running refresh counter. It composites the returned ROM pixels with color-key transparency. It also tracks whether the player has ever stood on one ground block (the "iced" flag). It sits between the VGA timing generator / game-state logic and the external background and sprite ROMs.

## Interface
Parameters:
- ANIM_PERIOD, 6_000_000: refresh counter terminal count; the counter period is ANIM_PERIOD+1 cycles.
- BG_W, 551: background width in pixels.
- BG_H, 401: background height in pixels.
- SPR_W, 47: player sprite width in pixels.
- SPR_H, 41: player sprite height in pixels.
- BLK_W, 28: ground block width in pixels.
- KEY0, 12'h428: first transparent sprite color.
- KEY1, 12'h028: second transparent sprite color.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- col_addr_x, in, 10: scan column.
- row_addr_y, in, 9: scan row.
- x_blue, in, 10: player top-left x.
- y_blue, in, 9: player top-left y.
- blue_state, in, 3: [0] facing (0 = left, 1 = right), [1] airborne, [2] moving.
- x_ground, in, 10: block top-left x.
- y_ground, in, 9: block top-left y.
- bg_addr, out, 19: background ROM address.
- blue_addr, out, 14: sprite ROM address.
- blue_sel, out, 3: sprite bank select = {facing, frame[1:0]}.
- bg_pix, in, 12: background ROM data; synchronous read, 1-cycle latency.
- blue_pix, in, 12: sprite ROM data; synchronous read, 1-cycle latency.
- pixel_out, out, 12: composited RGB444 pixel.
- touched, out, 1: sticky flag, set once the player has stood on the block.

## Operation
- All comparisons and arithmetic use at least 11-bit unsigned values, so x+46 and y+40 never wrap.
- Background address, registered:
  - bg_addr = y*BG_W + x when x ≤ BG_W-1 and y ≤ BG_H-1.
  - Otherwise bg_addr = 0.
- Sprite window: bx ≤ x ≤ bx+SPR_W-1 and by ≤ y ≤ by+SPR_H-1, where (bx, by) = (x_blue, y_blue).
  - Inside the window: blue_addr = (y-by)*SPR_W + (x-bx).
  - Outside the window: blue_addr = 0.
  - The registered hit flag blue_hit_q1 is captured in the same stage as blue_addr.
- Refresh counter ipcnt (32-bit):
  - Increments every cycle.
  - When it equals ANIM_PERIOD it loads 0 (wrap).
- Frame counter (2-bit):
  - On each wrap, frame increments mod 4 when blue_state[2]=1.
  - On each wrap, frame is forced to 0 when blue_state[2]=0.
  - Between wraps, frame holds its value.
- Bank select: blue_sel = {blue_state[0], frame}, registered together with blue_addr.
- Compositing (final stage):
  - pixel_out = blue_pix when hit_q2 = 1 and blue_pix ≠ KEY0 and blue_pix ≠ KEY1.
  - Otherwise pixel_out = bg_pix.
  - Both color keys are transparent.
- Block icing (touch detection):
  - Condition: y_blue + SPR_H == y_ground (player feet row immediately above the block top) and the ranges [x_blue, x_blue+SPR_W-1] and [x_ground, x_ground+BLK_W-1] overlap.
  - touched is set on the cycle after the condition holds.
  - touched stays set until rst.
  - Detection is independent of the scan coordinates.

## Timing
- Reset values: bg_addr=0, blue_addr=0, blue_sel=0, pixel_out=0, touched=0, ipcnt=0, frame=0, all hit pipeline flags=0.
- Pipeline:
  - Cycle N: coordinates presented.
  - Cycle N+1: bg_addr, blue_addr and blue_sel valid.
  - Cycle N+2: ROM data valid.
  - Cycle N+3: pixel_out valid.
- The hit flag is delayed two stages (hit_q1 → hit_q2) to align with the ROM data.
- Throughput is one pixel per clock, with no stalls or handshake.
- Boundary conditions:
  - A window is inclusive at both edges. Example: x = x_blue+46 is inside; x = x_blue+47 is outside.
  - The background is out of range at x = 551 or y = 401; bg_addr = 0 there.
  - Transitions of blue_state[2] take effect only at the next wrap.
- Reset mid-operation: on the next edge, every register returns to its reset value, including touched and ipcnt. Pipeline contents are discarded.

## Test plan
- Reset, then x=10, y=2 -> bg_addr=1112 at N+1; x=551 -> bg_addr=0; x=550, y=400 -> bg_addr=220950.
- x_blue=100, y_blue=50; scan (146,90) -> blue_addr=1926. Scan (147,90) -> blue_addr=0, and pixel_out=bg_pix at N+3.
- Inside the sprite window:
  - blue_pix=12'h428 -> pixel_out=bg_pix.
  - blue_pix=12'h028 -> pixel_out=bg_pix.
  - blue_pix=12'hFFF -> pixel_out=12'hFFF, appearing exactly 3 cycles after the coordinates.
- ANIM_PERIOD=3, blue_state=3'b101 -> blue_sel steps 4,5,6,7,4 every 4 cycles. Clearing bit 2 -> blue_sel=4 after the next wrap.
- Block icing:
  - x_ground=56, y_ground=374, y_blue=333, x_blue=20 -> touched=1 next cycle.
  - Moving the player away afterwards -> touched stays 1.
  - x_blue=85 (no overlap) on a fresh reset -> touched stays 0.
- Assert rst mid-stream with touched=1 -> all outputs 0 on the next edge; the counter restarts from 0.
